tpx3_lane_align: RTL and testbench
==================================

TPX3_LANE_ALIGN -- requirements
Module: tpx3_lane_align

Interface
REQ-001 Parameter SEARCH_WIN, default 64: valid words without an aligned comma before a bitslip is requested.
REQ-002 Parameter SLIP_WAIT, default 4: clock cycles after a bitslip during which input words are ignored.
REQ-003 Parameter LOCK_COUNT, default 16: consecutive aligned commas required to declare lock.
REQ-004 Parameter LOSS_COUNT, default 4: consecutive misaligned-comma events that drop lock.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 Port CLK, input, 1: deserialised-word clock; all logic is on its rising edge.
REQ-007 Port RST_N, input, 1: synchronous active-low reset.
REQ-008 Port DATA_IN, input, 10: raw 10b word from one Timepix3 DataOut lane deserialiser; bit 9 is the first bit received ("a").
REQ-009 Port DATA_VALID, input, 1: DATA_IN is valid this cycle.
REQ-010 Port BITSLIP, output, 1: one-cycle pulse requesting a one-bit deserialiser slip.
REQ-011 Port LOCKED, output, 1: lane word alignment is established.
REQ-012 Port DATA_OUT, output, 10: aligned word forwarded to the 8b10b decoder.
REQ-013 Port DATA_OUT_VALID, output, 1: DATA_OUT is valid.
REQ-014 Port SLIP_CNT, output, 4: current slip offset, 0..9.
REQ-015 Port ERR_CNT, output, 16: saturating count of misaligned-comma events.
REQ-016 Port LOSS_CNT, output, 8: saturating count of lock losses.

Function
REQ-017 An aligned comma is DATA_IN equal to 10'b0011111010 or 10'b1100000101 (K28.5, either running disparity).
REQ-018 A misaligned event is a 7-bit pattern 0011111 or 1100000 found in {previous valid word, DATA_IN} at bit offsets 1..9, where offset 0 is the aligned position; the aligned comma takes priority when both conditions hold.
REQ-019 The FSM states are SEARCH, SLIP_WAIT, CONFIRM and LOCKED; words without DATA_VALID do not advance counters or state.
REQ-020 In SEARCH, an aligned comma moves to CONFIRM with the comma count set to 1; otherwise the window count increments.
REQ-021 In SEARCH, the SEARCH_WIN-th non-comma word pulses BITSLIP in the next cycle, increments SLIP_CNT (9 wraps to 0) and moves to SLIP_WAIT.
REQ-022 SLIP_WAIT lasts exactly SLIP_WAIT clock cycles regardless of DATA_VALID, clears the window count and then returns to SEARCH.
REQ-023 In CONFIRM, an aligned comma increments the comma count and a non-comma word returns to SEARCH without a slip; reaching LOCK_COUNT moves to LOCKED.
REQ-024 In LOCKED, a misaligned event increments the loss counter and ERR_CNT, and an aligned comma clears the loss counter; other words leave it unchanged.
REQ-025 When the loss counter reaches LOSS_COUNT, the FSM moves to SEARCH, increments LOSS_CNT and deasserts LOCKED in the same edge.
REQ-026 LOCKED is high exactly while the state is LOCKED.
REQ-027 DATA_OUT and DATA_OUT_VALID are registered with 1-cycle latency; DATA_OUT_VALID = DATA_VALID AND (state == LOCKED), sampled in the input cycle.
REQ-028 The word completing CONFIRM is not forwarded; the word that triggers loss of lock is forwarded.
REQ-029 ERR_CNT and LOSS_CNT hold at all-ones and never wrap.

Reset
REQ-030 On RST_N low at a clock edge: state becomes SEARCH; all internal counters and the previous-word register clear to 0.
REQ-031 On reset, outputs BITSLIP, LOCKED, DATA_OUT_VALID, SLIP_CNT, ERR_CNT and LOSS_CNT become 0, and DATA_OUT becomes 10'h000.
REQ-032 Reset asserted mid-SLIP_WAIT or mid-LOCKED takes priority over every transition in the same cycle.

Structure
REQ-033 The K28.5 codes, the comma 7-bit patterns and the FSM state encodings belong in the shared Timepix3 8b10b include file.
REQ-034 Comma detection (aligned flag, misaligned flag) is one sub-module, tpx3_comma_detect, which is combinational over the 20-bit window.

Verification
REQ-035 Bench scenario: K28.5 RD- stream continuous at offset 0 -> LOCKED rises after 16 valid words; DATA_OUT_VALID follows 1 cycle later; BITSLIP never pulses.
REQ-036 Bench scenario: comma stream shifted 3 bits -> 3 BITSLIP pulses, each separated by 64 words + 4 cycles; SLIP_CNT=3; then lock.
REQ-037 Bench scenario: locked lane, then 4 misaligned commas -> LOCKED=0 after the 4th; ERR_CNT=4; LOSS_CNT=1.
REQ-038 Bench scenario: locked lane, misaligned commas 3 times, then 1 aligned comma, then 3 more misaligned -> stays LOCKED; ERR_CNT=6.
REQ-039 Bench scenario: CONFIRM at count 10, then a data word 10'h2AA -> SEARCH; no BITSLIP; SLIP_CNT unchanged.
REQ-040 Bench scenario: 10 slips with no comma -> SLIP_CNT wraps 9->0; RST_N low during SLIP_WAIT -> next edge state=SEARCH with all outputs 0.

Source files
------------

// File: rtl/tpx3_lane_align_pkg.sv
// Shared Timepix3 8b10b definitions: K28.5 codes, 7-bit comma patterns,
// word-alignment FSM encoding and small saturating-counter helpers.
package tpx3_lane_align_pkg;

   typedef logic [9:0] word10_t;

   // K28.5 in both running disparities; bit 9 is the first bit on the wire
   localparam word10_t K28_5_RDN = 10'b0011111010;
   localparam word10_t K28_5_RDP = 10'b1100000101;

   // 7-bit comma sequences that only occur at a symbol boundary
   localparam logic [6:0] COMMA_P7 = 7'b0011111;
   localparam logic [6:0] COMMA_N7 = 7'b1100000;

   // Highest deserialiser slip offset before wrapping to 0
   localparam logic [3:0] SLIP_OFFSET_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_SEARCH    = 2'd0,
      ST_SLIP_WAIT = 2'd1,
      ST_CONFIRM   = 2'd2,
      ST_LOCKED    = 2'd3
   } align_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [3:0] slip_next(input logic [3:0] v);
      return (v >= SLIP_OFFSET_MAX) ? 4'd0 : v + 4'd1;
   endfunction

endpackage

// File: rtl/tpx3_lane_align_if.sv
// Lane-side bundle: raw deserialised words in, aligned words and status out.
interface tpx3_lane_align_if;
   import tpx3_lane_align_pkg::*;

   word10_t     DATA_IN;
   logic        DATA_VALID;
   logic        BITSLIP;
   logic        LOCKED;
   word10_t     DATA_OUT;
   logic        DATA_OUT_VALID;
   logic [3:0]  SLIP_CNT;
   logic [15:0] ERR_CNT;
   logic [7:0]  LOSS_CNT;

   // Deserialiser / test side
   modport master (
      output DATA_IN, DATA_VALID,
      input  BITSLIP, LOCKED, DATA_OUT, DATA_OUT_VALID, SLIP_CNT, ERR_CNT, LOSS_CNT
   );

   // Aligner side
   modport slave (
      input  DATA_IN, DATA_VALID,
      output BITSLIP, LOCKED, DATA_OUT, DATA_OUT_VALID, SLIP_CNT, ERR_CNT, LOSS_CNT
   );

endinterface

// File: rtl/tpx3_comma_detect.sv
// Combinational comma finder over {previous valid word, current word}.
// Offset 0 (current word bits 9:3) is the aligned position; offsets 1..9
// start inside the previous word and indicate a word-boundary slip.
module tpx3_comma_detect
   import tpx3_lane_align_pkg::*;
(
   input  logic [19:0] window_i,
   output logic        aligned_o,
   output logic        misaligned_o
);

   logic hit;

   // Aligned K28.5 wins over any off-boundary comma in the same window
   always_comb begin
      aligned_o    = (window_i[9:0] == K28_5_RDN) || (window_i[9:0] == K28_5_RDP);
      hit          = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         if ((window_i[k+3 +: 7] == COMMA_P7) || (window_i[k+3 +: 7] == COMMA_N7)) begin
            hit = 1'b1;
         end
      end
      misaligned_o = hit && !aligned_o;
   end

endmodule

// File: rtl/tpx3_lane_align.sv
// Timepix3 DataOut lane word aligner: hunts for K28.5 at the word boundary,
// requests deserialiser bitslips when none is found, confirms lock over a run
// of aligned commas and drops lock after repeated misaligned commas.
module tpx3_lane_align
   import tpx3_lane_align_pkg::*;
#(
   parameter int unsigned SEARCH_WIN = 64,
   parameter int unsigned SLIP_WAIT  = 4,
   parameter int unsigned LOCK_COUNT = 16,
   parameter int unsigned LOSS_COUNT = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   tpx3_lane_align_if.slave lane
);

   localparam int unsigned WIN_W  = $clog2(SEARCH_WIN + 1);
   localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);
   localparam int unsigned CMA_W  = $clog2(LOCK_COUNT + 1);
   localparam int unsigned LOSS_W = $clog2(LOSS_COUNT + 1);

   // Terminal values: the event that reaches the count happens while the
   // register still holds count-1
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WIN - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
   localparam logic [CMA_W-1:0]  CMA_LAST  = CMA_W'(LOCK_COUNT - 1);
   localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_COUNT - 1);

   align_state_e      state_q, state_d;
   logic [WIN_W-1:0]  win_q, win_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CMA_W-1:0]  cma_q, cma_d;
   logic [LOSS_W-1:0] loss_q, loss_d;
   word10_t           prev_q, prev_d;
   logic [3:0]        slip_cnt_q, slip_cnt_d;
   logic [15:0]       err_q, err_d;
   logic [7:0]        loss_cnt_q, loss_cnt_d;
   logic              bitslip_q, bitslip_d;
   word10_t           dout_q, dout_d;
   logic              dvld_q, dvld_d;

   logic              aligned;
   logic              misaligned;

   tpx3_comma_detect u_comma (
      .window_i     ({prev_q, lane.DATA_IN}),
      .aligned_o    (aligned),
      .misaligned_o (misaligned)
   );

   // Next-state and counter updates; invalid words only advance SLIP_WAIT
   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      wait_d     = wait_q;
      cma_d      = cma_q;
      loss_d     = loss_q;
      slip_cnt_d = slip_cnt_q;
      err_d      = err_q;
      loss_cnt_d = loss_cnt_q;
      bitslip_d  = 1'b0;
      prev_d     = lane.DATA_VALID ? lane.DATA_IN : prev_q;
      dout_d     = lane.DATA_IN;
      dvld_d     = lane.DATA_VALID && (state_q == ST_LOCKED);

      case (state_q)
         ST_SLIP_WAIT: begin
            // Deserialiser output is unsettled after a slip: count cycles, not words
            if (wait_q == WAIT_LAST) begin
               state_d = ST_SEARCH;
               wait_d  = '0;
               win_d   = '0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         ST_SEARCH: begin
            if (lane.DATA_VALID) begin
               if (aligned) begin
                  cma_d   = CMA_W'(1);
                  state_d = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_CONFIRM;
                  loss_d  = '0;
               end else if (win_q == WIN_LAST) begin
                  bitslip_d  = 1'b1;
                  slip_cnt_d = slip_next(slip_cnt_q);
                  state_d    = ST_SLIP_WAIT;
                  win_d      = '0;
                  wait_d     = '0;
               end else begin
                  win_d = win_q + 1'b1;
               end
            end
         end

         ST_CONFIRM: begin
            if (lane.DATA_VALID) begin
               if (aligned) begin
                  if (cma_q == CMA_LAST) begin
                     state_d = ST_LOCKED;
                     loss_d  = '0;
                  end else begin
                     cma_d = cma_q + 1'b1;
                  end
               end else begin
                  // A single stray word restarts the hunt at the current offset
                  state_d = ST_SEARCH;
                  cma_d   = '0;
                  win_d   = '0;
               end
            end
         end

         ST_LOCKED: begin
            if (lane.DATA_VALID) begin
               if (aligned) begin
                  loss_d = '0;
               end else if (misaligned) begin
                  err_d = sat_inc16(err_q);
                  if (loss_q == LOSS_LAST) begin
                     state_d    = ST_SEARCH;
                     loss_d     = '0;
                     win_d      = '0;
                     cma_d      = '0;
                     loss_cnt_d = sat_inc8(loss_cnt_q);
                  end else begin
                     loss_d = loss_q + 1'b1;
                  end
               end
            end
         end

         default: begin
            state_d = ST_SEARCH;
         end
      endcase
   end

   // State, counters and registered outputs; reset overrides every transition
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= ST_SEARCH;
         win_q      <= '0;
         wait_q     <= '0;
         cma_q      <= '0;
         loss_q     <= '0;
         prev_q     <= '0;
         slip_cnt_q <= '0;
         err_q      <= '0;
         loss_cnt_q <= '0;
         bitslip_q  <= 1'b0;
         dout_q     <= '0;
         dvld_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         wait_q     <= wait_d;
         cma_q      <= cma_d;
         loss_q     <= loss_d;
         prev_q     <= prev_d;
         slip_cnt_q <= slip_cnt_d;
         err_q      <= err_d;
         loss_cnt_q <= loss_cnt_d;
         bitslip_q  <= bitslip_d;
         dout_q     <= dout_d;
         dvld_q     <= dvld_d;
      end
   end

   assign lane.BITSLIP        = bitslip_q;
   assign lane.LOCKED         = (state_q == ST_LOCKED);
   assign lane.DATA_OUT       = dout_q;
   assign lane.DATA_OUT_VALID = dvld_q;
   assign lane.SLIP_CNT       = slip_cnt_q;
   assign lane.ERR_CNT        = err_q;
   assign lane.LOSS_CNT       = loss_cnt_q;

endmodule

// File: tb/tb_tpx3_lane_align.sv
// Bench for tpx3_lane_align: directed scenarios plus randomized traffic,
// all checked against a behavioural lane-alignment model.
module tb_tpx3_lane_align;

   localparam logic [9:0] KN   = 10'b0011111010;
   localparam logic [9:0] KP   = 10'b1100000101;
   // Comma that straddles the word boundary (starts in the last bit of the
   // previous word) whenever it follows itself or an aligned RD- comma
   localparam logic [9:0] XMIS = 10'b0111110000;
   localparam int SW    = 64;
   localparam int SWAIT = 4;
   localparam int LC    = 16;
   localparam int LSC   = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tpx3_lane_align_if bus ();

   tpx3_lane_align #(
      .SEARCH_WIN (SW),
      .SLIP_WAIT  (SWAIT),
      .LOCK_COUNT (LC),
      .LOSS_COUNT (LSC)
   ) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .lane  (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   // ---------------- behavioural model ----------------
   string      m_mode;
   int         m_win, m_wait, m_cma, m_loss;
   logic [9:0] m_prev, m_dout;
   bit         m_slip, m_dov;
   int         m_slipcnt, m_err, m_losscnt;

   function automatic bit is_comma(logic [9:0] w);
      return (w == KN) || (w == KP);
   endfunction

   // Look for a 7-bit comma starting at wire positions 1..9 of the two-word
   // bit sequence (position 0 = first bit of previous word, 10 = aligned).
   function automatic bit has_mis(logic [9:0] prev, logic [9:0] cur);
      bit seq[20];
      logic [6:0] w;
      for (int i = 0; i < 10; i++) begin
         seq[i]      = prev[9-i];
         seq[i + 10] = cur[9-i];
      end
      for (int s = 1; s <= 9; s++) begin
         w = '0;
         for (int j = 0; j < 7; j++) w = {w[5:0], seq[s+j]};
         if (w == 7'b0011111 || w == 7'b1100000) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void model_reset();
      m_mode = "SEARCH";
      m_win = 0; m_wait = 0; m_cma = 0; m_loss = 0;
      m_prev = '0; m_dout = '0; m_slip = 0; m_dov = 0;
      m_slipcnt = 0; m_err = 0; m_losscnt = 0;
   endfunction

   function automatic void model_step(bit v, logic [9:0] d);
      bit comma;
      bit mis;
      if (!rst_n) begin
         model_reset();
         return;
      end
      comma  = is_comma(d);
      mis    = !comma && has_mis(m_prev, d);
      m_dov  = v && (m_mode == "LOCKED");
      m_dout = d;
      m_slip = 0;
      if (m_mode == "SLIP_WAIT") begin
         m_wait++;
         if (m_wait == SWAIT) begin
            m_mode = "SEARCH";
            m_win  = 0;
         end
      end else if (v) begin
         if (m_mode == "SEARCH") begin
            if (comma) begin
               m_cma = 1;
               if (LC == 1) m_mode = "LOCKED"; else m_mode = "CONFIRM";
            end else begin
               m_win++;
               if (m_win == SW) begin
                  m_slip    = 1;
                  m_slipcnt = (m_slipcnt + 1) % 10;
                  m_mode    = "SLIP_WAIT";
                  m_wait    = 0;
                  m_win     = 0;
               end
            end
         end else if (m_mode == "CONFIRM") begin
            if (comma) begin
               m_cma++;
               if (m_cma == LC) begin
                  m_mode = "LOCKED";
                  m_loss = 0;
               end
            end else begin
               m_mode = "SEARCH";
               m_win  = 0;
            end
         end else begin
            if (comma) m_loss = 0;
            else if (mis) begin
               if (m_err < 65535) m_err++;
               m_loss++;
               if (m_loss == LSC) begin
                  m_mode = "SEARCH";
                  m_win  = 0;
                  m_loss = 0;
                  if (m_losscnt < 255) m_losscnt++;
               end
            end
         end
      end
      if (v) m_prev = d;
   endfunction

   function automatic logic [40:0] dut_vec();
      return {bus.BITSLIP, bus.LOCKED, bus.DATA_OUT_VALID, bus.DATA_OUT,
              bus.SLIP_CNT, bus.ERR_CNT, bus.LOSS_CNT};
   endfunction

   function automatic logic [40:0] mdl_vec();
      logic lk;
      lk = (m_mode == "LOCKED");
      return {m_slip, lk, m_dov, m_dout, 4'(m_slipcnt), 16'(m_err), 8'(m_losscnt)};
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic logic [9:0] rotl(logic [9:0] x, int n);
      logic [9:0] r;
      r = x;
      for (int i = 0; i < n; i++) r = {r[8:0], r[9]};
      return r;
   endfunction

   function automatic logic [9:0] noise();
      logic [9:0] w;
      do w = 10'($urandom); while (w == KN || w == KP);
      return w;
   endfunction

   task automatic tick(input bit v, input logic [9:0] d);
      bus.DATA_VALID = v;
      bus.DATA_IN    = d;
      @(posedge clk);
      model_step(v, d);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(1'b1, noise());
      tick(1'b0, noise());
      rst_n = 1'b1;
   endtask

   task automatic lock_lane();
      for (int i = 0; i < LC; i++) tick(1'b1, KN);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b1, KN);
      n_total++;
      if (dut_vec() !== 41'h0) $display("FAIL reset_outputs got %h want %h", dut_vec(), 41'h0);
      else n_pass++;
      rst_n = 1'b1;
      tick(1'b0, 10'h155);
      n_total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL reset_release got %h want %h", dut_vec(), mdl_vec());
      else n_pass++;
   endtask

   task automatic test_lock_aligned();
      int lock_at = -1;
      int dov_at  = -1;
      int slips   = 0;
      do_reset();
      for (int i = 1; i <= 24; i++) begin
         tick(1'b1, KN);
         n_total++;
         if (dut_vec() !== mdl_vec()) $display("FAIL lock_aligned_model word %0d got %h want %h", i, dut_vec(), mdl_vec());
         else n_pass++;
         if (bus.LOCKED === 1'b1 && lock_at < 0) lock_at = i;
         if (bus.DATA_OUT_VALID === 1'b1 && dov_at < 0) dov_at = i;
         if (bus.BITSLIP !== 1'b0) slips++;
      end
      n_total++;
      if (lock_at !== 16) $display("FAIL lock_aligned_rise got word %0d want word 16", lock_at); else n_pass++;
      n_total++;
      if (dov_at !== 17) $display("FAIL lock_aligned_dov got word %0d want word 17", dov_at); else n_pass++;
      n_total++;
      if (slips !== 0) $display("FAIL lock_aligned_bitslip got %0d pulses want 0", slips); else n_pass++;
   endtask

   task automatic test_slip_shift3();
      int phase   = 7;
      int lock_at = -1;
      int slip_at[$];
      do_reset();
      for (int i = 1; i <= 400 && lock_at < 0; i++) begin
         tick(1'b1, rotl(KN, phase));
         n_total++;
         if (dut_vec() !== mdl_vec()) $display("FAIL shift3_model cycle %0d got %h want %h", i, dut_vec(), mdl_vec());
         else n_pass++;
         if (bus.BITSLIP === 1'b1) begin
            slip_at.push_back(i);
            phase = (phase + 1) % 10;
         end
         if (bus.LOCKED === 1'b1) lock_at = i;
      end
      n_total++;
      if (slip_at.size() !== 3) $display("FAIL shift3_slips got %0d want 3", slip_at.size()); else n_pass++;
      if (slip_at.size() >= 3) begin
         n_total++;
         if (slip_at[0] !== 64) $display("FAIL shift3_first_slip got cycle %0d want 64", slip_at[0]); else n_pass++;
         for (int k = 1; k < 3; k++) begin
            n_total++;
            if (slip_at[k] - slip_at[k-1] !== 68)
               $display("FAIL shift3_gap%0d got %0d want 68", k, slip_at[k] - slip_at[k-1]);
            else n_pass++;
         end
      end
      n_total++;
      if (lock_at !== 220) $display("FAIL shift3_lock got cycle %0d want 220", lock_at); else n_pass++;
      n_total++;
      if (bus.SLIP_CNT !== 4'd3) $display("FAIL shift3_slip_cnt got %0d want 3", bus.SLIP_CNT); else n_pass++;
   endtask

   task automatic test_loss_of_lock();
      do_reset();
      lock_lane();
      tick(1'b1, KN);
      tick(1'b1, KN);
      for (int k = 1; k <= 4; k++) begin
         tick(1'b1, XMIS);
         n_total++;
         if (dut_vec() !== mdl_vec()) $display("FAIL loss_model mis %0d got %h want %h", k, dut_vec(), mdl_vec());
         else n_pass++;
         if (k == 3) begin
            n_total++;
            if (bus.LOCKED !== 1'b1) $display("FAIL loss_hold_after3 got %b want 1", bus.LOCKED); else n_pass++;
         end
      end
      n_total++;
      if ({bus.LOCKED, bus.ERR_CNT, bus.LOSS_CNT} !== {1'b0, 16'd4, 8'd1})
         $display("FAIL loss_status got locked=%b err=%0d loss=%0d want locked=0 err=4 loss=1",
                  bus.LOCKED, bus.ERR_CNT, bus.LOSS_CNT);
      else n_pass++;
      n_total++;
      if ({bus.DATA_OUT_VALID, bus.DATA_OUT} !== {1'b1, XMIS})
         $display("FAIL loss_word_forwarded got v=%b d=%h want v=1 d=%h", bus.DATA_OUT_VALID, bus.DATA_OUT, XMIS);
      else n_pass++;
      tick(1'b1, XMIS);
      n_total++;
      if (bus.DATA_OUT_VALID !== 1'b0) $display("FAIL loss_after_dov got %b want 0", bus.DATA_OUT_VALID); else n_pass++;
   endtask

   task automatic test_recover();
      do_reset();
      lock_lane();
      for (int k = 0; k < 3; k++) tick(1'b1, XMIS);
      tick(1'b1, KN);
      for (int k = 0; k < 3; k++) tick(1'b1, XMIS);
      n_total++;
      if ({bus.LOCKED, bus.ERR_CNT, bus.LOSS_CNT} !== {1'b1, 16'd6, 8'd0})
         $display("FAIL recover_status got locked=%b err=%0d loss=%0d want locked=1 err=6 loss=0",
                  bus.LOCKED, bus.ERR_CNT, bus.LOSS_CNT);
      else n_pass++;
      n_total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL recover_model got %h want %h", dut_vec(), mdl_vec()); else n_pass++;
      // reset while locked, with a misaligned word that would otherwise drop lock
      rst_n = 1'b0;
      tick(1'b1, XMIS);
      n_total++;
      if (dut_vec() !== 41'h0) $display("FAIL reset_in_locked got %h want %h", dut_vec(), 41'h0); else n_pass++;
      rst_n = 1'b1;
      tick(1'b1, KN);
      n_total++;
      if (bus.LOCKED !== 1'b0) $display("FAIL reset_in_locked_state got %b want 0", bus.LOCKED); else n_pass++;
   endtask

   task automatic test_confirm_abort();
      do_reset();
      for (int i = 0; i < SW; i++) tick(1'b1, noise());
      for (int i = 0; i < SWAIT; i++) tick(1'b0, noise());
      for (int i = 0; i < 10; i++) tick(1'b1, KN);
      tick(1'b1, 10'h2AA);
      n_total++;
      if ({bus.BITSLIP, bus.LOCKED, bus.SLIP_CNT} !== {1'b0, 1'b0, 4'd1})
         $display("FAIL confirm_abort got slip=%b locked=%b slip_cnt=%0d want slip=0 locked=0 slip_cnt=1",
                  bus.BITSLIP, bus.LOCKED, bus.SLIP_CNT);
      else n_pass++;
      n_total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL confirm_abort_model got %h want %h", dut_vec(), mdl_vec()); else n_pass++;
      for (int i = 0; i < LC - 1; i++) tick(1'b1, KN);
      n_total++;
      if (bus.LOCKED !== 1'b0) $display("FAIL confirm_restart_early got %b want 0", bus.LOCKED); else n_pass++;
      tick(1'b1, KN);
      n_total++;
      if (bus.LOCKED !== 1'b1) $display("FAIL confirm_restart_lock got %b want 1", bus.LOCKED); else n_pass++;
   endtask

   task automatic test_slip_wrap_reset();
      int slips    = 0;
      int first_at = -1;
      do_reset();
      for (int i = 0; i < 3000 && slips < 10; i++) begin
         tick($urandom_range(0, 3) != 0, noise());
         n_total++;
         if (dut_vec() !== mdl_vec()) $display("FAIL wrap_model cycle %0d got %h want %h", i, dut_vec(), mdl_vec());
         else n_pass++;
         if (bus.BITSLIP === 1'b1) begin
            slips++;
            n_total++;
            if (bus.SLIP_CNT !== 4'(slips % 10))
               $display("FAIL wrap_slip_cnt slip %0d got %0d want %0d", slips, bus.SLIP_CNT, slips % 10);
            else n_pass++;
         end
      end
      n_total++;
      if (slips !== 10) $display("FAIL wrap_slip_total got %0d want 10", slips); else n_pass++;
      tick(1'b1, noise());
      rst_n = 1'b0;
      tick(1'b1, noise());
      n_total++;
      if (dut_vec() !== 41'h0) $display("FAIL reset_in_slip_wait got %h want %h", dut_vec(), 41'h0); else n_pass++;
      rst_n = 1'b1;
      for (int i = 1; i <= SW; i++) begin
         tick(1'b1, noise());
         if (bus.BITSLIP === 1'b1 && first_at < 0) first_at = i;
      end
      n_total++;
      if (first_at !== SW) $display("FAIL reset_window_restart got word %0d want %0d", first_at, SW); else n_pass++;
   endtask

   task automatic test_random();
      int seg_left = 0;
      int kind     = 0;
      logic [9:0] w;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (seg_left == 0) begin
            kind     = $urandom_range(0, 3);
            seg_left = $urandom_range(1, 40);
         end
         seg_left--;
         case (kind)
            0:       w = KN;
            1:       w = XMIS;
            2:       w = noise();
            default: w = KP;
         endcase
         tick($urandom_range(0, 9) != 0, w);
         n_total++;
         if (dut_vec() !== mdl_vec()) $display("FAIL random_model cycle %0d got %h want %h", i, dut_vec(), mdl_vec());
         else n_pass++;
      end
   endtask

   task automatic test_loss_saturate();
      do_reset();
      for (int r = 0; r < 260; r++) begin
         lock_lane();
         for (int k = 0; k < LSC; k++) tick(1'b1, XMIS);
         n_total++;
         if (dut_vec() !== mdl_vec()) $display("FAIL saturate_model round %0d got %h want %h", r, dut_vec(), mdl_vec());
         else n_pass++;
      end
      n_total++;
      if ({bus.LOSS_CNT, bus.ERR_CNT} !== {8'd255, 16'd1040})
         $display("FAIL saturate_counts got loss=%0d err=%0d want loss=255 err=1040", bus.LOSS_CNT, bus.ERR_CNT);
      else n_pass++;
   endtask

   initial begin
      bus.DATA_IN    = '0;
      bus.DATA_VALID = 1'b0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_lock_aligned();
      test_slip_shift3();
      test_loss_of_lock();
      test_recover();
      test_confirm_abort();
      test_slip_wrap_reset();
      test_random();
      test_loss_saturate();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
